// File: rtl/mem_arbiter_if.sv
// Bundle of fetch, data and shared-memory handshake signals around mem_arbiter.
// slave = arbiter side, master = requesters plus memory model.
interface mem_arbiter_if;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_ack;
    logic [31:0] i_rdata;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        m_valid;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic        m_ready;
    logic [31:0] m_rdata;
    logic        stall;
    logic        timeout_err;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_ready, m_rdata,
        output i_ack, i_rdata, d_ack, d_rdata, m_valid, m_we, m_addr, m_wdata,
               stall, timeout_err
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_ready, m_rdata,
        input  i_ack, i_rdata, d_ack, d_rdata, m_valid, m_we, m_addr, m_wdata,
               stall, timeout_err
    );
endinterface

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter onto one memory port: grant one edge after req, ack combinational on m_ready,
// abort after MAX_WAIT stalled cycles; `MEM_ARB_RR_EN selects alternating priority instead of data-first.
module mem_arbiter #(
    parameter int unsigned MAX_WAIT = 15
) (
    input logic          clk,
    input logic          reset,
    mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

    localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT);

    state_t      state;
    logic [7:0]  wait_cnt;
    logic        m_valid_q;
    logic        cmd_we;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        err_q;
    logic        busy;
    logic        abort;
    logic        fin;
    logic        grant_d;

`ifdef MEM_ARB_RR_EN
    logic last_d;
    // On conflict the side that did not win last time goes first.
    assign grant_d = bus.d_req & ~(bus.i_req & last_d);
`else
    assign grant_d = bus.d_req;
`endif

    assign busy  = (state != IDLE);
    // A ready memory on the limit cycle counts as a normal completion.
    assign abort = busy & ~bus.m_ready & (wait_cnt == WAIT_LIMIT);
    assign fin   = busy & (bus.m_ready | abort);

    assign bus.i_ack   = fin & (state == BUSY_I);
    assign bus.d_ack   = fin & (state == BUSY_D);
    assign bus.i_rdata = ((state == BUSY_I) && bus.m_ready) ? bus.m_rdata : 32'd0;
    assign bus.d_rdata = ((state == BUSY_D) && bus.m_ready) ? bus.m_rdata : 32'd0;

    assign bus.m_valid     = m_valid_q;
    assign bus.m_we        = cmd_we;
    assign bus.m_addr      = cmd_addr;
    assign bus.m_wdata     = cmd_wdata;
    assign bus.timeout_err = err_q;
    assign bus.stall       = (bus.i_req & ~bus.i_ack) | (bus.d_req & ~bus.d_ack);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            wait_cnt  <= 8'd0;
            m_valid_q <= 1'b0;
            cmd_we    <= 1'b0;
            cmd_addr  <= 32'd0;
            cmd_wdata <= 32'd0;
            err_q     <= 1'b0;
`ifdef MEM_ARB_RR_EN
            last_d    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.d_req | bus.i_req) begin
                        state     <= grant_d ? BUSY_D : BUSY_I;
                        m_valid_q <= 1'b1;
                        wait_cnt  <= 8'd0;
                        cmd_we    <= grant_d & bus.d_we;
                        cmd_addr  <= grant_d ? bus.d_addr : bus.i_addr;
                        cmd_wdata <= grant_d ? bus.d_wdata : 32'd0;
`ifdef MEM_ARB_RR_EN
                        last_d    <= grant_d;
`endif
                    end
                end
                default: begin
                    if (fin) begin
                        state     <= IDLE;
                        m_valid_q <= 1'b0;
                        if (abort) begin
                            err_q <= 1'b1;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-level reference model checked every cycle plus directed literal checks.
module tb_mem_arbiter;
    localparam int MAXW = 15;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   errors = 0;
    int   checks = 0;

    mem_arbiter_if bus();

    mem_arbiter #(.MAX_WAIT(MAXW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one outstanding transfer described by owner, command and cycles waited.
    bit          xfer_open  = 1'b0;
    bit          xfer_data  = 1'b0;
    bit          xfer_we    = 1'b0;
    logic [31:0] xfer_addr  = '0;
    logic [31:0] xfer_wdata = '0;
    int          xfer_wait  = 0;
    bit          sticky_err = 1'b0;
    bit          last_was_d = 1'b0;
    bit          pick_d;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            xfer_open  = 1'b0;
            xfer_wait  = 0;
            sticky_err = 1'b0;
            last_was_d = 1'b0;
        end else if (!xfer_open) begin
            if (bus.d_req || bus.i_req) begin
                pick_d = bus.d_req;
`ifdef MEM_ARB_RR_EN
                if (bus.d_req && bus.i_req) pick_d = !last_was_d;
`endif
                xfer_open  = 1'b1;
                xfer_data  = pick_d;
                last_was_d = pick_d;
                xfer_wait  = 0;
                xfer_addr  = pick_d ? bus.d_addr : bus.i_addr;
                xfer_we    = pick_d ? bus.d_we : 1'b0;
                xfer_wdata = pick_d ? bus.d_wdata : 32'd0;
            end
        end else if (bus.m_ready) begin
            xfer_open = 1'b0;
        end else if (xfer_wait == MAXW) begin
            xfer_open  = 1'b0;
            sticky_err = 1'b1;
        end else begin
            xfer_wait++;
        end
    end

    always @(negedge clk) begin
        bit done, e_i, e_d;
        done = xfer_open && (bus.m_ready || xfer_wait == MAXW);
        e_i  = done && !xfer_data;
        e_d  = done && xfer_data;
        chk("m_valid", bus.m_valid, xfer_open);
        chk("i_ack", bus.i_ack, e_i);
        chk("d_ack", bus.d_ack, e_d);
        chk("i_rdata", bus.i_rdata, (e_i && bus.m_ready) ? bus.m_rdata : 32'd0);
        chk("d_rdata", bus.d_rdata, (e_d && bus.m_ready) ? bus.m_rdata : 32'd0);
        chk("stall", bus.stall, (bus.i_req && !e_i) || (bus.d_req && !e_d));
        chk("timeout_err", bus.timeout_err, sticky_err);
        if (xfer_open) begin
            chk("m_addr", bus.m_addr, xfer_addr);
            chk("m_we", bus.m_we, xfer_we);
            chk("m_wdata", bus.m_wdata, xfer_wdata);
        end
    end

    task automatic drive_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    int   stall_n, we_n, busy_n, n_acks;
    bit   seen_ack;
    logic grant_seq [3];
    logic exp_seq   [3];

    initial begin
        bus.i_req = 0; bus.i_addr = 0; bus.d_req = 0; bus.d_we = 0;
        bus.d_addr = 0; bus.d_wdata = 0; bus.m_ready = 0; bus.m_rdata = 0;

        // Reset state
        @(negedge clk);
        chk("rst_m_valid", bus.m_valid, 0);
        chk("rst_m_addr", bus.m_addr, 0);
        chk("rst_m_we", bus.m_we, 0);
        chk("rst_m_wdata", bus.m_wdata, 0);
        chk("rst_timeout_err", bus.timeout_err, 0);
        do_reset();

        // Single fetch, memory ready immediately
        bus.i_req = 1; bus.i_addr = 32'h100; bus.m_ready = 1; bus.m_rdata = 32'h1234_5678;
        @(negedge clk);
        chk("f_idle_stall", bus.stall, 1);
        chk("f_idle_valid", bus.m_valid, 0);
        @(negedge clk);
        chk("f_valid", bus.m_valid, 1);
        chk("f_addr", bus.m_addr, 32'h100);
        chk("f_we", bus.m_we, 0);
        chk("f_ack", bus.i_ack, 1);
        chk("f_rdata", bus.i_rdata, 32'h1234_5678);
        drive_edge();
        bus.i_req = 0; bus.m_ready = 0;
        @(negedge clk);
        chk("f_ack_after", bus.i_ack, 0);
        chk("f_stall_after", bus.stall, 0);

        // Store with three wait cycles
        drive_edge();
        bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h40; bus.d_wdata = 32'hDEAD_BEEF;
        bus.m_rdata = 32'h0BAD_F00D;
        stall_n = 0; we_n = 0;
        @(negedge clk);
        stall_n += int'(bus.stall);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            stall_n += int'(bus.stall);
            we_n    += int'(bus.m_valid && bus.m_we);
            chk("s_no_ack", bus.d_ack, 0);
        end
        drive_edge();
        bus.m_ready = 1;
        @(negedge clk);
        stall_n += int'(bus.stall);
        we_n    += int'(bus.m_valid && bus.m_we);
        chk("s_ack", bus.d_ack, 1);
        chk("s_addr", bus.m_addr, 32'h40);
        chk("s_wdata", bus.m_wdata, 32'hDEAD_BEEF);
        chk("s_rdata", bus.d_rdata, 32'h0BAD_F00D);
        drive_edge();
        bus.d_req = 0; bus.d_we = 0; bus.m_ready = 0;
        @(negedge clk);
        stall_n += int'(bus.stall);
        chk("s_stall_cycles", stall_n, 4);
        chk("s_we_cycles", we_n, 4);

        // Conflict held across three transfers, from a fresh priority state
        do_reset();
        bus.i_req = 1; bus.i_addr = 32'h200; bus.d_req = 1; bus.d_addr = 32'h300;
        bus.m_ready = 1; bus.m_rdata = 32'h5555_0000;
        n_acks = 0;
        for (int c = 0; c < 12 && n_acks < 3; c++) begin
            @(negedge clk);
            if (bus.i_ack || bus.d_ack) begin
                grant_seq[n_acks] = bus.d_ack;
                n_acks++;
            end
        end
        drive_edge();
        bus.i_req = 0; bus.d_req = 0; bus.m_ready = 0;
        chk("c_ack_count", n_acks, 3);
`ifdef MEM_ARB_RR_EN
        exp_seq[0] = 1; exp_seq[1] = 0; exp_seq[2] = 1;
`else
        exp_seq[0] = 1; exp_seq[1] = 1; exp_seq[2] = 1;
`endif
        for (int k = 0; k < 3; k++) chk("c_grant_is_d", grant_seq[k], exp_seq[k]);

        // m_ready arrives on the limit cycle: normal completion
        drive_edge();
        bus.i_req = 1; bus.i_addr = 32'h500; bus.m_rdata = 32'hCAFE_0001;
        @(negedge clk);
        for (int k = 0; k < MAXW; k++) @(negedge clk);
        chk("b_no_ack_15", bus.i_ack, 0);
        drive_edge();
        bus.m_ready = 1;
        @(negedge clk);
        chk("b_ack_16", bus.i_ack, 1);
        chk("b_rdata_16", bus.i_rdata, 32'hCAFE_0001);
        drive_edge();
        bus.i_req = 0; bus.m_ready = 0;
        @(negedge clk);
        chk("b_no_err", bus.timeout_err, 0);

        // Memory never ready: timeout abort
        drive_edge();
        bus.i_req = 1; bus.i_addr = 32'h540; bus.m_rdata = 32'hA5A5_A5A5;
        busy_n = 0; seen_ack = 0;
        for (int c = 0; c < 40 && !seen_ack; c++) begin
            @(negedge clk);
            busy_n += int'(bus.m_valid);
            if (bus.i_ack) begin
                seen_ack = 1;
                chk("t_rdata", bus.i_rdata, 0);
            end
        end
        chk("t_ack_seen", seen_ack, 1);
        chk("t_busy_cycles", busy_n, 16);
        drive_edge();
        bus.i_req = 0;
        repeat (4) @(negedge clk);
        chk("t_err_sticky", bus.timeout_err, 1);

        // Reset in the middle of a data transfer, fetch waiting
        drive_edge();
        bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h600; bus.d_wdata = 32'h0000_0066;
        @(negedge clk);
        @(negedge clk);
        chk("r_busy_before", bus.m_valid, 1);
        @(posedge clk);
        #2 reset = 1'b0;
        bus.i_req = 1; bus.i_addr = 32'h700;
        #1;
        chk("r_valid", bus.m_valid, 0);
        chk("r_d_ack", bus.d_ack, 0);
        chk("r_err", bus.timeout_err, 0);
        chk("r_addr", bus.m_addr, 0);
        chk("r_we", bus.m_we, 0);
        bus.d_req = 0; bus.d_we = 0;
        @(posedge clk);
        #3 reset = 1'b1;
        bus.m_ready = 1; bus.m_rdata = 32'h7777_0007;
        @(negedge clk);
        chk("r_idle_valid", bus.m_valid, 0);
        @(negedge clk);
        chk("r_grant_valid", bus.m_valid, 1);
        chk("r_grant_addr", bus.m_addr, 32'h700);
        chk("r_grant_ack", bus.i_ack, 1);
        drive_edge();
        bus.i_req = 0; bus.m_ready = 0;
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
